adc_reg_reader: RTL and testbench

Serial register read-back engine for the two ADCs' 3-wire configuration port. It initiates the opposite direction to the existing write-only ADC initialisation sequencer. On request, it runs a three-frame sequence (enable readout, address/read frame, disable readout) on SEN/SCLK/SDATA. During the read frame it captures the ADC's SDOUT and returns the 8-bit register value. It sits in the CLKB domain next to the init sequencer; the top level muxes the serial pins to this block once initialisation is done.

---
 rtl/adc_ser_pkg.sv | 20 ++
 rtl/adc_ser_frame.sv | 77 +++++++
 rtl/adc_reg_reader.sv | 124 ++++++++++++
 tb/tb_adc_reg_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ser_pkg.sv
// rtl/adc_ser_pkg.sv - shared constants and state type for the ADC 3-wire port
package adc_ser_pkg;

  // Register 0 holds the READOUT control bit; writing 1 switches SDOUT to register readback
  localparam logic [7:0] READOUT_REG = 8'h00;
  localparam logic [7:0] READOUT_EN  = 8'h01;
  localparam int         FRAME_BITS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F_EN,
    ST_G1,
    ST_F_RD,
    ST_G2,
    ST_F_DIS,
    ST_G3,
    ST_DONE
  } state_t;

endpackage

// File: rtl/adc_ser_frame.sv
// rtl/adc_ser_frame.sv - one 16-bit MSB-first frame on SEN/SCLK/SDATA
module adc_ser_frame
  import adc_ser_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        CLKB,
  input  logic        RESET,
  input  logic        start,
  input  logic [15:0] word,
  output logic        sen,
  output logic        sclk,
  output logic        sdata,
  output logic        sample,
  output logic        frame_done
);

  // A frame is a run of CLK_DIV-long half periods: setup, 16 x (low, high), hold
  localparam int         LAST_HALF = 2 * FRAME_BITS + 1;
  localparam logic [5:0] HALF_LAST = 6'(LAST_HALF);
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);

  logic        running;
  logic [7:0]  div_cnt;
  logic [5:0]  half;
  logic [15:0] shreg;
  logic        div_end;

  assign div_end    = running && (div_cnt == DIV_LAST);
  // Odd halves are low phases of a bit; leaving one raises sclk, which is when sdout is taken
  assign sample     = div_end && half[0] && (half != HALF_LAST);
  assign frame_done = div_end && (half == HALF_LAST);

  // Half-period sequencer driving the registered serial pins
  always_ff @(posedge CLKB or negedge RESET) begin
    if (!RESET) begin
      running <= 1'b0;
      div_cnt <= 8'd0;
      half    <= 6'd0;
      shreg   <= 16'h0000;
      sen     <= 1'b1;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
    end else if (!running) begin
      if (start) begin
        running <= 1'b1;
        div_cnt <= 8'd0;
        half    <= 6'd0;
        shreg   <= {word[14:0], 1'b0};
        sen     <= 1'b0;
        sclk    <= 1'b0;
        sdata   <= word[15];
      end
    end else if (!div_end) begin
      div_cnt <= div_cnt + 8'd1;
    end else begin
      div_cnt <= 8'd0;
      half    <= half + 6'd1;
      if (half == HALF_LAST) begin
        running <= 1'b0;
        sen     <= 1'b1;
        sclk    <= 1'b0;
        sdata   <= 1'b0;
      end else if (half[0]) begin
        sclk <= 1'b1;
      end else begin
        sclk <= 1'b0;
        // Setup already shows bit 15; after the last high phase only the hold remains
        if (half != 6'd0 && half != HALF_LAST - 6'd1) begin
          sdata <= shreg[15];
          shreg <= {shreg[14:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/adc_reg_reader.sv
// rtl/adc_reg_reader.sv - ADC register read-back engine over the 3-wire port
module adc_reg_reader
  import adc_ser_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SEN_GAP = 8
) (
  input  logic       CLKB,
  input  logic       RESET,
  input  logic       init_done,
  input  logic       req,
  input  logic [7:0] addr,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sen,
  output logic       sclk,
  output logic       sdata,
  input  logic       sdout
);

  localparam logic [7:0] GAP_LAST = 8'(SEN_GAP - 1);

  state_t      state;
  logic [7:0]  addr_q;
  logic [7:0]  gap_cnt;
  logic [7:0]  cap_sr;
  logic        gap_end;
  logic        start;
  logic [15:0] word;
  logic        sample;
  logic        frame_done;

  assign gap_end = (gap_cnt == 8'd0);

  // Launch a frame on an accepted request or when a gap expires, so sen falls on the same edge
  always_comb begin
    start = 1'b0;
    word  = 16'h0000;
    case (state)
      ST_IDLE: begin
        start = init_done & req;
        word  = {READOUT_REG, READOUT_EN};
      end
      ST_G1: begin
        start = gap_end;
        word  = {addr_q, 8'h00};
      end
      ST_G2: begin
        start = gap_end;
        word  = {READOUT_REG, 8'h00};
      end
      default: ;
    endcase
  end

  adc_ser_frame #(
    .CLK_DIV (CLK_DIV)
  ) u_frame (
    .CLKB       (CLKB),
    .RESET      (RESET),
    .start      (start),
    .word       (word),
    .sen        (sen),
    .sclk       (sclk),
    .sdata      (sdata),
    .sample     (sample),
    .frame_done (frame_done)
  );

  // Sequence control, gap timing and capture; only the last 8 samples of the read frame survive
  always_ff @(posedge CLKB or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      addr_q  <= 8'h00;
      gap_cnt <= 8'd0;
      cap_sr  <= 8'h00;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sample && state == ST_F_RD) begin
        cap_sr <= {cap_sr[6:0], sdout};
      end
      case (state)
        ST_IDLE: begin
          if (init_done && req) begin
            addr_q <= addr;
            busy   <= 1'b1;
            state  <= ST_F_EN;
          end
        end
        ST_F_EN, ST_F_RD, ST_F_DIS: begin
          if (frame_done) begin
            gap_cnt <= GAP_LAST;
            state   <= (state == ST_F_EN) ? ST_G1 :
                       (state == ST_F_RD) ? ST_G2 : ST_G3;
          end
        end
        ST_G1, ST_G2: begin
          if (gap_end) begin
            state <= (state == ST_G1) ? ST_F_RD : ST_F_DIS;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        ST_G3: begin
          if (gap_end) begin
            rdata <= cap_sr;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_reg_reader.sv
// tb/tb_adc_reg_reader.sv - randomized bench with ADC behavioural model and protocol watch
module tb_adc_reg_reader;

  logic       CLKB = 1'b0;
  logic       RESET;
  logic       init_done;
  logic [1:0] req;
  logic [7:0] addr [2];
  logic [1:0] busy, done, sen, sclk, sdata;
  logic [1:0] sdout = 2'b00;
  logic [7:0] rdata [2];

  // Instance 0 uses defaults, instance 1 the divider/gap extremes
  int div_p [2] = '{4, 1};
  int gap_p [2] = '{8, 1};

  // ADC model state
  logic [7:0]  regs [2][256];
  logic [15:0] fr [2][8];
  int          nfr [2];
  int          rise_cnt [2];
  logic [15:0] mosi_sr [2];
  logic [7:0]  dout_val [2];
  logic        readout [2];
  logic        prev_sen [2];
  logic        prev_sclk [2];
  logic        prev_sdata [2];
  int          busy_cycles [2];
  int          done_count [2];
  int          done_cyc [2];
  int          fall_cyc [2];
  logic        armed [2];
  int          sen_low [2];
  int          viol_sclk [2];
  int          viol_sdata [2];
  int          cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  adc_reg_reader u_dut0 (
    .CLKB      (CLKB),
    .RESET     (RESET),
    .init_done (init_done),
    .req       (req[0]),
    .addr      (addr[0]),
    .busy      (busy[0]),
    .done      (done[0]),
    .rdata     (rdata[0]),
    .sen       (sen[0]),
    .sclk      (sclk[0]),
    .sdata     (sdata[0]),
    .sdout     (sdout[0])
  );

  adc_reg_reader #(
    .CLK_DIV (1),
    .SEN_GAP (1)
  ) u_dut1 (
    .CLKB      (CLKB),
    .RESET     (RESET),
    .init_done (init_done),
    .req       (req[1]),
    .addr      (addr[1]),
    .busy      (busy[1]),
    .done      (done[1]),
    .rdata     (rdata[1]),
    .sen       (sen[1]),
    .sclk      (sclk[1]),
    .sdata     (sdata[1]),
    .sdout     (sdout[1])
  );

  always #5 CLKB = ~CLKB;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      nfr[i] = 0; rise_cnt[i] = 0; mosi_sr[i] = '0; dout_val[i] = '0; readout[i] = 1'b0;
      prev_sen[i] = 1'b1; prev_sclk[i] = 1'b0; prev_sdata[i] = 1'b0;
      busy_cycles[i] = 0; done_count[i] = 0; done_cyc[i] = 0; fall_cyc[i] = 0;
      armed[i] = 1'b0; sen_low[i] = 0; viol_sclk[i] = 0; viol_sdata[i] = 0;
    end
  end

  // ADC side: decode MOSI frames, track READOUT, shift register data onto SDOUT, watch the protocol
  always @(negedge CLKB) begin
    for (int i = 0; i < 2; i++) begin
      if (sen[i] && sclk[i]) viol_sclk[i]++;
      if (prev_sclk[i] && sclk[i] && sdata[i] != prev_sdata[i]) viol_sdata[i]++;
      if (busy[i]) busy_cycles[i]++;
      if (done[i]) begin done_count[i]++; done_cyc[i] = cyc; end
      if (!sen[i]) begin
        sen_low[i]++;
        if (prev_sen[i]) begin
          rise_cnt[i] = 0;
          if (armed[i]) begin fall_cyc[i] = cyc; armed[i] = 1'b0; end
        end
        if (sclk[i] && !prev_sclk[i]) begin
          mosi_sr[i] = {mosi_sr[i][14:0], sdata[i]};
          rise_cnt[i]++;
          if (rise_cnt[i] == 8) begin
            dout_val[i] = readout[i] ? regs[i][mosi_sr[i][7:0]] : 8'h00;
            sdout[i] = dout_val[i][7];
          end else if (rise_cnt[i] > 8 && rise_cnt[i] < 16) begin
            sdout[i] = dout_val[i][15 - rise_cnt[i]];
          end
        end
      end else if (!prev_sen[i]) begin
        sdout[i] = 1'b0;
        if (rise_cnt[i] == 16) begin
          if (nfr[i] < 8) fr[i][nfr[i]] = mosi_sr[i];
          nfr[i]++;
          if (mosi_sr[i][15:8] == 8'h00) readout[i] = mosi_sr[i][0];
        end
      end
      prev_sen[i]   = sen[i];
      prev_sclk[i]  = sclk[i];
      prev_sdata[i] = sdata[i];
    end
    cyc++;
  end

  task automatic do_read(input int i, input logic [7:0] a, input logic [7:0] v, input int extra_at);
    int t;
    int lat_exp;
    lat_exp = 3 * (34 * div_p[i] + gap_p[i]);
    regs[i][a] = v;
    nfr[i] = 0; done_count[i] = 0; busy_cycles[i] = 0; armed[i] = 1'b1;
    @(posedge CLKB); #1;
    req[i] = 1'b1; addr[i] = a;
    @(posedge CLKB); #1;
    req[i] = 1'b0; addr[i] = 8'($urandom);
    t = 1;
    while (done_count[i] == 0 && t < 2000) begin
      if (t == extra_at) begin
        req[i] = 1'b1; addr[i] = ~a;
        @(posedge CLKB); #1;
        req[i] = 1'b0;
        t++;
      end else begin
        @(posedge CLKB); #1;
        t++;
      end
    end
    check($sformatf("done_seen_%0d", i), done_count[i] != 0, 1);
    repeat (20) @(posedge CLKB);
    #1;
    check($sformatf("done_once_%0d", i), done_count[i], 1);
    check($sformatf("rdata_%0d_a%0h", i, a), rdata[i], v);
    check($sformatf("nframes_%0d", i), nfr[i], 3);
    check($sformatf("frame_en_%0d", i), fr[i][0], 16'h0001);
    check($sformatf("frame_rd_%0d", i), fr[i][1], {a, 8'h00});
    check($sformatf("frame_dis_%0d", i), fr[i][2], 16'h0000);
    check($sformatf("latency_%0d", i), done_cyc[i] - fall_cyc[i], lat_exp);
    check($sformatf("busy_len_%0d", i), busy_cycles[i], lat_exp);
    check($sformatf("busy_idle_%0d", i), busy[i], 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_sen_%0d", tag, i), sen[i], 1);
      check($sformatf("%s_sclk_%0d", tag, i), sclk[i], 0);
      check($sformatf("%s_sdata_%0d", tag, i), sdata[i], 0);
      check($sformatf("%s_busy_%0d", tag, i), busy[i], 0);
      check($sformatf("%s_done_%0d", tag, i), done[i], 0);
      check($sformatf("%s_rdata_%0d", tag, i), rdata[i], 8'h00);
    end
  endtask

  initial begin
    int t;
    RESET = 1'b1; init_done = 1'b0; req = 2'b00; addr[0] = 8'h00; addr[1] = 8'h00;
    #1 RESET = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge CLKB);
    #3 RESET = 1'b1;
    repeat (2) @(posedge CLKB);

    // Requests while init is not finished must be dropped
    sen_low[0] = 0; done_count[0] = 0;
    @(posedge CLKB); #1;
    req[0] = 1'b1; addr[0] = 8'h3D;
    @(posedge CLKB); #1;
    req[0] = 1'b0;
    repeat (100) @(posedge CLKB);
    check("gate_sen", sen_low[0], 0);
    check("gate_done", done_count[0], 0);
    check("gate_busy", busy[0], 0);

    init_done = 1'b1;
    do_read(0, 8'h3D, 8'hA5, 0);
    do_read(0, 8'h42, 8'h96, 10);
    do_read(1, 8'h3D, 8'h5A, 0);
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 2; i++) begin
        do_read(i, 8'($urandom_range(1, 255)), 8'($urandom), 0);
      end
    end

    // Abort during bit 10 of the read frame
    regs[0][8'h77] = 8'h3C; nfr[0] = 0; done_count[0] = 0;
    @(posedge CLKB); #1;
    req[0] = 1'b1; addr[0] = 8'h77;
    @(posedge CLKB); #1;
    req[0] = 1'b0;
    t = 0;
    while (!(nfr[0] == 1 && !sen[0] && rise_cnt[0] == 5) && t < 1000) begin
      @(posedge CLKB);
      t++;
    end
    check("abort_reach", t < 1000, 1);
    repeat (4) @(posedge CLKB);
    #3 RESET = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (3) @(posedge CLKB);
    #2 RESET = 1'b1;
    repeat (600) @(posedge CLKB);
    #1;
    check("abort_no_done", done_count[0], 0);
    check("abort_rdata", rdata[0], 8'h00);
    do_read(0, 8'h01, 8'hFF, 0);

    for (int i = 0; i < 2; i++) begin
      check($sformatf("proto_sclk_sen_%0d", i), viol_sclk[i], 0);
      check($sformatf("proto_sdata_stable_%0d", i), viol_sdata[i], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
